// File: rtl/frame_buf_ring.sv
// Single-clock N-frame ring address generator for an external-memory frame buffer.
// Writer fills whole frames and reader drains whole frames, with a stall or drop-oldest overflow policy.
module frame_buf_ring #(
    parameter int ADDR_WIDTH  = 29,
    parameter int BASE_ADDR   = 2,
    parameter int BUF_SIZE    = 500,
    parameter int NUM_FRAMES  = 2,
    parameter int DROP_OLDEST = 0,
    localparam int CW = $clog2(NUM_FRAMES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic                  rd_en_in,
    input  logic                  wr_rdy,
    input  logic                  rd_rdy,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic                  overflow,
    output logic [CW-1:0]         frames_avail
);

    localparam int FW = ($clog2(NUM_FRAMES) > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int WW = ($clog2(BUF_SIZE) > 1) ? $clog2(BUF_SIZE) : 1;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_READ = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] BASE         = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(BUF_SIZE);
    localparam logic [WW-1:0]         LAST_WORD    = WW'(BUF_SIZE - 1);
    localparam logic [FW-1:0]         LAST_FRAME   = FW'(NUM_FRAMES - 1);
    localparam logic [CW-1:0]         FULL         = CW'(NUM_FRAMES);

    logic [0:0]            w_state_q, w_state_d;
    logic [0:0]            r_state_q, r_state_d;
    logic [FW-1:0]         wr_frame_q, wr_frame_d;
    logic [FW-1:0]         rd_frame_q, rd_frame_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [WW-1:0]         wr_word_q, wr_word_d;
    logic [WW-1:0]         rd_word_q, rd_word_d;
    logic [CW-1:0]         avail_q, avail_d;

    logic wr_beat, rd_beat, wr_last, rd_last, full, drop;

    assign wr_en   = ~((w_state_q == W_FILL) & ~wr_en_in);
    assign rd_en   = ~((r_state_q == R_READ) & ~rd_en_in);
    assign wr_beat = ~wr_en & wr_rdy;
    assign rd_beat = ~rd_en & rd_rdy;
    assign wr_last = wr_beat & (wr_word_q == LAST_WORD);
    assign rd_last = rd_beat & (rd_word_q == LAST_WORD);
    assign full    = (avail_q == FULL);

    // A drop only happens when the reader is idle and not asking to start, so the reader always wins.
    assign drop = (DROP_OLDEST != 0) && (w_state_q == W_IDLE) && !wr_en_in && full
                  && (r_state_q == R_IDLE) && rd_en_in;

    assign wr_addr       = wr_addr_q;
    assign rd_addr       = rd_addr_q;
    assign wr_frame_done = wr_last;
    assign rd_frame_done = rd_last;
    assign overflow      = drop;
    assign frames_avail  = avail_q;

    always_comb begin
        w_state_d  = w_state_q;
        wr_frame_d = wr_frame_q;
        wr_addr_d  = wr_addr_q;
        wr_word_d  = wr_word_q;
        case (w_state_q)
            W_IDLE: begin
                if (!wr_en_in && (!full || drop)) begin
                    w_state_d = W_FILL;
                end
            end
            default: begin
                if (wr_last) begin
                    w_state_d  = W_IDLE;
                    wr_word_d  = '0;
                    wr_frame_d = (wr_frame_q == LAST_FRAME) ? '0 : wr_frame_q + FW'(1);
                    wr_addr_d  = (wr_frame_q == LAST_FRAME) ? BASE : wr_addr_q + ADDR_WIDTH'(1);
                end else if (wr_beat) begin
                    wr_word_d = wr_word_q + WW'(1);
                    wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    // Dropping the oldest frame advances the read pointer a whole frame while the reader sits idle.
    always_comb begin
        r_state_d  = r_state_q;
        rd_frame_d = rd_frame_q;
        rd_addr_d  = rd_addr_q;
        rd_word_d  = rd_word_q;
        case (r_state_q)
            R_IDLE: begin
                if (!rd_en_in && (avail_q != '0)) begin
                    r_state_d = R_READ;
                end else if (drop) begin
                    rd_frame_d = (rd_frame_q == LAST_FRAME) ? '0 : rd_frame_q + FW'(1);
                    rd_addr_d  = (rd_frame_q == LAST_FRAME) ? BASE : rd_addr_q + FRAME_STRIDE;
                end
            end
            default: begin
                if (rd_last) begin
                    r_state_d  = R_IDLE;
                    rd_word_d  = '0;
                    rd_frame_d = (rd_frame_q == LAST_FRAME) ? '0 : rd_frame_q + FW'(1);
                    rd_addr_d  = (rd_frame_q == LAST_FRAME) ? BASE : rd_addr_q + ADDR_WIDTH'(1);
                end else if (rd_beat) begin
                    rd_word_d = rd_word_q + WW'(1);
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    always_comb begin
        avail_d = avail_q;
        case ({wr_last, rd_last | drop})
            2'b10:   avail_d = avail_q + CW'(1);
            2'b01:   avail_d = avail_q - CW'(1);
            default: avail_d = avail_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            wr_frame_q <= '0;
            rd_frame_q <= '0;
            wr_addr_q  <= BASE;
            rd_addr_q  <= BASE;
            wr_word_q  <= '0;
            rd_word_q  <= '0;
            avail_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wr_frame_q <= wr_frame_d;
            rd_frame_q <= rd_frame_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_word_q  <= wr_word_d;
            rd_word_q  <= rd_word_d;
            avail_q    <= avail_d;
        end
    end

endmodule

// File: tb/tb_frame_buf_ring.sv
// Scoreboard bench for frame_buf_ring: instance a uses the stall policy, instance b drops the oldest frame.
// Expected beats are queued by the stimulus and popped by a negedge monitor.
module tb_frame_buf_ring;

    localparam int AW = 29;

    logic clk = 1'b0;
    logic rst_n;

    logic wr_en_in_a, rd_en_in_a, wr_rdy_a, rd_rdy_a;
    logic wr_en_a, rd_en_a, wr_frame_done_a, rd_frame_done_a, overflow_a;
    logic [AW-1:0] wr_addr_a, rd_addr_a;
    logic [1:0] frames_avail_a;

    logic wr_en_in_b, rd_en_in_b, wr_rdy_b, rd_rdy_b;
    logic wr_en_b, rd_en_b, wr_frame_done_b, rd_frame_done_b, overflow_b;
    logic [AW-1:0] wr_addr_b, rd_addr_b;
    logic [1:0] frames_avail_b;

    int tests = 0;
    int failures = 0;
    int wbeats_a = 0, rbeats_a = 0, wbeats_b = 0, rbeats_b = 0, ov_cnt_b = 0;

    logic [AW:0]   wq_a[$], rq_a[$], wq_b[$], rq_b[$];
    logic [AW-1:0] ovq_b[$];

    always #5 clk = ~clk;

    frame_buf_ring #(.ADDR_WIDTH(AW), .BASE_ADDR(2), .BUF_SIZE(4), .NUM_FRAMES(3), .DROP_OLDEST(0)) dut_a (
        .clk(clk), .reset(rst_n), .wr_en_in(wr_en_in_a), .rd_en_in(rd_en_in_a),
        .wr_rdy(wr_rdy_a), .rd_rdy(rd_rdy_a), .wr_en(wr_en_a), .rd_en(rd_en_a),
        .wr_addr(wr_addr_a), .rd_addr(rd_addr_a), .wr_frame_done(wr_frame_done_a),
        .rd_frame_done(rd_frame_done_a), .overflow(overflow_a), .frames_avail(frames_avail_a)
    );

    frame_buf_ring #(.ADDR_WIDTH(AW), .BASE_ADDR(2), .BUF_SIZE(4), .NUM_FRAMES(3), .DROP_OLDEST(1)) dut_b (
        .clk(clk), .reset(rst_n), .wr_en_in(wr_en_in_b), .rd_en_in(rd_en_in_b),
        .wr_rdy(wr_rdy_b), .rd_rdy(rd_rdy_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .wr_addr(wr_addr_b), .rd_addr(rd_addr_b), .wr_frame_done(wr_frame_done_b),
        .rd_frame_done(rd_frame_done_b), .overflow(overflow_b), .frames_avail(frames_avail_b)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue selector: 0 write a, 1 read a, 2 write b, 3 read b.
    task automatic push_frame(input int sel, input int base);
        logic [AW:0] e;
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), AW'(base + i)};
            case (sel)
                0: wq_a.push_back(e);
                1: rq_a.push_back(e);
                2: wq_b.push_back(e);
                default: rq_b.push_back(e);
            endcase
        end
    endtask

    task automatic mon_pop(input int sel, input logic [AW:0] act, input string name);
        logic [AW:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        case (sel)
            0: if (wq_a.size() > 0) begin e = wq_a.pop_front(); have = 1'b1; end
            1: if (rq_a.size() > 0) begin e = rq_a.pop_front(); have = 1'b1; end
            2: if (wq_b.size() > 0) begin e = wq_b.pop_front(); have = 1'b1; end
            default: if (rq_b.size() > 0) begin e = rq_b.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: unexpected beat got %0h expected none", name, act);
        end else begin
            check_output(name, act, e);
        end
    endtask

    task automatic wait_count(input int sel, input int target);
        int n;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            case (sel)
                0: n = wbeats_a;
                1: n = rbeats_a;
                2: n = wbeats_b;
                default: n = rbeats_b;
            endcase
            if (n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("beat_wait_timeout", 64'(ok), 64'd1);
    endtask

    // Monitor: beats are {done pulse, address} compared against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!wr_en_a && wr_rdy_a) begin
                mon_pop(0, {wr_frame_done_a, wr_addr_a}, "a_wr_beat");
                wbeats_a++;
            end
            if (!rd_en_a && rd_rdy_a) begin
                mon_pop(1, {rd_frame_done_a, rd_addr_a}, "a_rd_beat");
                rbeats_a++;
            end
            if (!wr_en_b && wr_rdy_b) begin
                mon_pop(2, {wr_frame_done_b, wr_addr_b}, "b_wr_beat");
                wbeats_b++;
            end
            if (!rd_en_b && rd_rdy_b) begin
                mon_pop(3, {rd_frame_done_b, rd_addr_b}, "b_rd_beat");
                rbeats_b++;
            end
            if (overflow_a) begin
                check_output("a_overflow_never", 64'(overflow_a), 64'd0);
            end
            if (overflow_b) begin
                if (ovq_b.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL b_overflow: unexpected pulse got 1 expected 0");
                end else begin
                    check_output("b_ovf_rd_addr", 64'(rd_addr_b), 64'(ovq_b.pop_front()));
                    check_output("b_ovf_avail", 64'(frames_avail_b), 64'd3);
                end
                ov_cnt_b++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en_in_a = 1'b1; rd_en_in_a = 1'b1; wr_rdy_a = 1'b0; rd_rdy_a = 1'b0;
        wr_en_in_b = 1'b1; rd_en_in_b = 1'b1; wr_rdy_b = 1'b0; rd_rdy_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_a_wr_en", 64'(wr_en_a), 64'd1);
        check_output("rst_a_rd_en", 64'(rd_en_a), 64'd1);
        check_output("rst_a_wr_addr", 64'(wr_addr_a), 64'd2);
        check_output("rst_a_rd_addr", 64'(rd_addr_a), 64'd2);
        check_output("rst_a_avail", 64'(frames_avail_a), 64'd0);
        check_output("rst_a_pulses", 64'({wr_frame_done_a, rd_frame_done_a, overflow_a}), 64'd0);
        check_output("rst_b_wr_addr", 64'(wr_addr_b), 64'd2);
        check_output("rst_b_avail", 64'(frames_avail_b), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reader asks with nothing available: no strobe.
        rd_en_in_b = 1'b0;
        rd_rdy_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("b_rd_en_empty", 64'(rd_en_b), 64'd1);
        end
        @(posedge clk); #1;
        rd_en_in_b = 1'b1;

        // Frame 0 on a, with wr_rdy paused mid-frame at address 3.
        push_frame(0, 2);
        wr_en_in_a = 1'b0;
        wr_rdy_a = 1'b1;
        wait_count(0, 1);
        @(posedge clk); #1;
        wr_rdy_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("a_pause_addr", 64'(wr_addr_a), 64'd3);
            check_output("a_pause_wr_en", 64'(wr_en_a), 64'd0);
            @(posedge clk); #1;
        end
        wr_rdy_a = 1'b1;
        wait_count(0, 4);
        @(posedge clk); #1;
        wr_en_in_a = 1'b1;
        check_output("a_f0_wr_addr", 64'(wr_addr_a), 64'd6);
        check_output("a_f0_avail", 64'(frames_avail_a), 64'd1);

        // Fill the ring on a; writer must stall.
        push_frame(0, 6);
        push_frame(0, 10);
        wr_en_in_a = 1'b0;
        wait_count(0, 12);
        @(posedge clk); #1;
        check_output("a_full_avail", 64'(frames_avail_a), 64'd3);
        check_output("a_full_wr_addr", 64'(wr_addr_a), 64'd2);
        repeat (3) begin
            @(negedge clk);
            check_output("a_stall_wr_en", 64'(wr_en_a), 64'd1);
        end

        // Read frame 0; the stalled writer then resumes at address 2.
        push_frame(1, 2);
        push_frame(0, 2);
        @(posedge clk); #1;
        rd_en_in_a = 1'b0;
        rd_rdy_a = 1'b1;
        wait_count(1, 4);
        @(posedge clk); #1;
        rd_en_in_a = 1'b1;
        check_output("a_rd0_rd_addr", 64'(rd_addr_a), 64'd6);
        check_output("a_rd0_avail", 64'(frames_avail_a), 64'd2);
        wait_count(0, 16);
        @(posedge clk); #1;
        wr_en_in_a = 1'b1;
        check_output("a_refill_avail", 64'(frames_avail_a), 64'd3);
        check_output("a_refill_wr_addr", 64'(wr_addr_a), 64'd6);

        // Read frame 1, then write frame 1 and read frame 2 finishing in the same cycle.
        push_frame(1, 6);
        rd_en_in_a = 1'b0;
        wait_count(1, 8);
        @(posedge clk); #1;
        rd_en_in_a = 1'b1;
        check_output("a_rd1_avail", 64'(frames_avail_a), 64'd2);
        push_frame(0, 6);
        push_frame(1, 10);
        wr_en_in_a = 1'b0;
        rd_en_in_a = 1'b0;
        wait_count(0, 20);
        check_output("a_sim_wr_done", 64'(wr_frame_done_a), 64'd1);
        check_output("a_sim_rd_done", 64'(rd_frame_done_a), 64'd1);
        @(posedge clk); #1;
        wr_en_in_a = 1'b1;
        rd_en_in_a = 1'b1;
        check_output("a_sim_avail", 64'(frames_avail_a), 64'd2);
        check_output("a_sim_rd_addr", 64'(rd_addr_a), 64'd2);

        // Drop-oldest on b: fourth frame with the ring full and reader idle.
        push_frame(2, 2);
        push_frame(2, 6);
        push_frame(2, 10);
        push_frame(2, 2);
        ovq_b.push_back(AW'(2));
        wr_rdy_b = 1'b1;
        wr_en_in_b = 1'b0;
        wait_count(2, 16);
        @(posedge clk); #1;
        wr_en_in_b = 1'b1;
        check_output("b_drop_rd_addr", 64'(rd_addr_b), 64'd6);
        check_output("b_drop_avail", 64'(frames_avail_b), 64'd3);
        check_output("b_drop_count", 64'(ov_cnt_b), 64'd1);
        push_frame(3, 6);
        rd_en_in_b = 1'b0;
        wait_count(3, 4);
        @(posedge clk); #1;
        rd_en_in_b = 1'b1;
        check_output("b_rd_avail", 64'(frames_avail_b), 64'd2);
        check_output("b_rd_addr_next", 64'(rd_addr_b), 64'd10);

        // Asynchronous reset in the middle of a frame.
        push_frame(0, 10);
        void'(wq_a.pop_back());
        void'(wq_a.pop_back());
        wr_en_in_a = 1'b0;
        wait_count(0, 22);
        rst_n = 1'b0;
        #1;
        check_output("arst_wr_en", 64'(wr_en_a), 64'd1);
        check_output("arst_wr_addr", 64'(wr_addr_a), 64'd2);
        check_output("arst_rd_addr", 64'(rd_addr_a), 64'd2);
        check_output("arst_avail", 64'(frames_avail_a), 64'd0);
        check_output("arst_b_avail", 64'(frames_avail_b), 64'd0);
        wr_en_in_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check_output("left_wq_a", 64'(wq_a.size()), 64'd0);
        check_output("left_rq_a", 64'(rq_a.size()), 64'd0);
        check_output("left_wq_b", 64'(wq_b.size()), 64'd0);
        check_output("left_rq_b", 64'(rq_b.size()), 64'd0);
        check_output("left_ovq_b", 64'(ovq_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
